// File: rtl/systolic_ctrl.sv
// Tile-pass sequencer for the systolic array: primes SRAM row reads, runs the compute
// window, then drains every output diagonal through a valid/ready handshake.
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_W     = 10,
  parameter int CYCLE_W    = 9,
  parameter int IDX_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  w_base_addr,
  input  logic [ADDR_W-1:0]  d_base_addr,
  output logic               sram_ren,
  output logic [ADDR_W-1:0]  sram_raddr_w,
  output logic [ADDR_W-1:0]  sram_raddr_d,
  output logic               feed_zero,
  output logic               alu_start,
  output logic [CYCLE_W-1:0] cycle_num,
  output logic [IDX_W-1:0]   matrix_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_e;

  localparam logic [CYCLE_W-1:0] RUN_LAST  = CYCLE_W'(3*ARRAY_SIZE-1);
  localparam logic [CYCLE_W-1:0] REN_END   = CYCLE_W'(ARRAY_SIZE-1);
  localparam logic [CYCLE_W-1:0] ZERO_FROM = CYCLE_W'(ARRAY_SIZE);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(2*ARRAY_SIZE-2);

  state_e state_q, state_d;

  logic               sram_ren_q, sram_ren_d;
  logic [ADDR_W-1:0]  raddr_w_q, raddr_w_d;
  logic [ADDR_W-1:0]  raddr_d_q, raddr_d_d;
  logic               feed_zero_q, feed_zero_d;
  logic               alu_start_q, alu_start_d;
  logic [CYCLE_W-1:0] cycle_num_q, cycle_num_d;
  logic [IDX_W-1:0]   matrix_index_q, matrix_index_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sram_ren_q     <= 1'b0;
      raddr_w_q      <= '0;
      raddr_d_q      <= '0;
      feed_zero_q    <= 1'b0;
      alu_start_q    <= 1'b0;
      cycle_num_q    <= '0;
      matrix_index_q <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sram_ren_q     <= sram_ren_d;
      raddr_w_q      <= raddr_w_d;
      raddr_d_q      <= raddr_d_d;
      feed_zero_q    <= feed_zero_d;
      alu_start_q    <= alu_start_d;
      cycle_num_q    <= cycle_num_d;
      matrix_index_q <= matrix_index_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PRIME;
      PRIME:   state_d = RUN;
      RUN:     if (cycle_num_q == RUN_LAST) state_d = DRAIN;
      DRAIN:   if (out_ready && matrix_index_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every other transition, including a start in IDLE.
    if (abort) state_d = IDLE;
  end

  // Outputs are the registered image of the state being entered.
  always_comb begin
    sram_ren_d     = 1'b0;
    raddr_w_d      = raddr_w_q;
    raddr_d_d      = raddr_d_q;
    feed_zero_d    = 1'b0;
    alu_start_d    = 1'b0;
    cycle_num_d    = cycle_num_q;
    matrix_index_d = matrix_index_q;
    out_valid_d    = 1'b0;
    busy_d         = 1'b1;
    done_d         = 1'b0;
    unique case (state_d)
      IDLE: begin
        raddr_w_d      = '0;
        raddr_d_d      = '0;
        cycle_num_d    = '0;
        matrix_index_d = '0;
        busy_d         = 1'b0;
      end
      PRIME: begin
        sram_ren_d = 1'b1;
        raddr_w_d  = w_base_addr;
        raddr_d_d  = d_base_addr;
      end
      RUN: begin
        alu_start_d = 1'b1;
        cycle_num_d = (state_q == RUN) ? cycle_num_q + CYCLE_W'(1) : '0;
        sram_ren_d  = (cycle_num_d < REN_END);
        if (sram_ren_d) begin
          raddr_w_d = raddr_w_q + ADDR_W'(1);
          raddr_d_d = raddr_d_q + ADDR_W'(1);
        end
        // Rows beyond the last one read see zeros, so row k meets the array at cycle k.
        feed_zero_d = (cycle_num_d >= ZERO_FROM);
      end
      DRAIN: begin
        out_valid_d = 1'b1;
        if (state_q != DRAIN)
          matrix_index_d = '0;
        else if (out_ready)
          matrix_index_d = matrix_index_q + IDX_W'(1);
      end
      DONE:    done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign sram_ren     = sram_ren_q;
  assign sram_raddr_w = raddr_w_q;
  assign sram_raddr_d = raddr_d_q;
  assign feed_zero    = feed_zero_q;
  assign alu_start    = alu_start_q;
  assign cycle_num    = cycle_num_q;
  assign matrix_index = matrix_index_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: each pass pushes its expected reads, compute cycles,
// diagonal beats and done time; a negedge monitor pops and compares them.
module tb_systolic_ctrl;
  localparam int AS = 16;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [9:0] w_base_addr = '0, d_base_addr = '0;
  logic       sram_ren, feed_zero, alu_start, out_valid, busy, done;
  logic [9:0] sram_raddr_w, sram_raddr_d;
  logic [8:0] cycle_num;
  logic [5:0] matrix_index;

  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct {int t; logic [9:0] w; logic [9:0] d;} ren_exp_t;
  typedef struct {int t; int cn;} alu_exp_t;
  ren_exp_t ren_q[$];
  alu_exp_t alu_q[$];
  int       idx_q[$];
  int       done_q[$];
  bit       rdy_pat[$];

  systolic_ctrl #(.ARRAY_SIZE(AS), .ADDR_W(10), .CYCLE_W(9), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_base_addr(w_base_addr), .d_base_addr(d_base_addr),
    .sram_ren(sram_ren), .sram_raddr_w(sram_raddr_w), .sram_raddr_d(sram_raddr_d),
    .feed_zero(feed_zero), .alu_start(alu_start), .cycle_num(cycle_num),
    .matrix_index(matrix_index), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flush();
    ren_q.delete();
    alu_q.delete();
    idx_q.delete();
    done_q.delete();
  endfunction

  // Monitor: every event the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    ren_exp_t re;
    alu_exp_t ae;
    int       t;
    if (!rst) begin
      if (sram_ren) begin
        if (ren_q.size() == 0) chk("ren_unexpected", 32'(sram_ren), 32'd0);
        else begin
          re = ren_q.pop_front();
          chk("ren_time", cyc, re.t);
          chk("raddr_w", 32'(sram_raddr_w), 32'(re.w));
          chk("raddr_d", 32'(sram_raddr_d), 32'(re.d));
        end
      end
      if (alu_start) begin
        if (alu_q.size() == 0) chk("alu_unexpected", 32'(alu_start), 32'd0);
        else begin
          ae = alu_q.pop_front();
          chk("alu_time", cyc, ae.t);
          chk("cycle_num", 32'(cycle_num), ae.cn);
          chk("feed_zero", 32'(feed_zero), 32'(ae.cn >= AS));
        end
      end
      if (out_valid) begin
        if (idx_q.size() == 0) chk("valid_unexpected", 32'(out_valid), 32'd0);
        else begin
          chk("matrix_index", 32'(matrix_index), idx_q[0]);
          if (out_ready) void'(idx_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else begin
          t = done_q.pop_front();
          chk("done_time", cyc, t);
          chk("done_cycle_num", 32'(cycle_num), 3*AS-1);
          chk("done_out_valid", 32'(out_valid), 32'd0);
          chk("done_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic chk_all_zero();
    chk("zero_ren", 32'(sram_ren), 32'd0);
    chk("zero_raddr_w", 32'(sram_raddr_w), 32'd0);
    chk("zero_raddr_d", 32'(sram_raddr_d), 32'd0);
    chk("zero_feed_zero", 32'(feed_zero), 32'd0);
    chk("zero_alu_start", 32'(alu_start), 32'd0);
    chk("zero_cycle_num", 32'(cycle_num), 32'd0);
    chk("zero_matrix_index", 32'(matrix_index), 32'd0);
    chk("zero_out_valid", 32'(out_valid), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_done", 32'(done), 32'd0);
  endtask

  // Drain-phase out_ready pattern; the pass ends on the 31st high entry.
  task automatic build_pattern(input int stall_at, input int stall_len, input bit rnd);
    int ones;
    bit r;
    ones = 0;
    rdy_pat.delete();
    while (ones < 2*AS-1) begin
      if (rnd) r = ($urandom_range(3) != 0);
      else r = !(stall_len > 0 && rdy_pat.size() >= stall_at && rdy_pat.size() < stall_at + stall_len);
      rdy_pat.push_back(r);
      if (r) ones++;
    end
  endtask

  // Issue start and load the scoreboard; p is the cycle in which PRIME is visible.
  task automatic launch(input logic [9:0] wb, input logic [9:0] db, input bit keep, output int p);
    logic [9:0] a, b;
    chk("launch_idle", 32'(busy), 32'd0);
    start = 1'b1;
    w_base_addr = wb;
    d_base_addr = db;
    @(posedge clk); #1;
    p = cyc;
    if (!keep) start = 1'b0;
    w_base_addr = 10'($urandom);
    d_base_addr = 10'($urandom);
    for (int k = 0; k < AS; k++) begin
      a = wb + 10'(k);
      b = db + 10'(k);
      ren_q.push_back('{p + k, a, b});
    end
    for (int k = 0; k < 3*AS; k++) alu_q.push_back('{p + 1 + k, k});
    for (int i = 0; i < 2*AS-1; i++) idx_q.push_back(i);
    done_q.push_back(p + 3*AS + 1 + rdy_pat.size());
    $display("[TB] pass at cycle %0d: w_base=%03h d_base=%03h drain_cycles=%0d", p, wb, db, rdy_pat.size());
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_matrix_index", 32'(matrix_index), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_still_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    flush();
    #1 chk_all_zero();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_ren", 32'(sram_ren), 32'd0);
  endtask

  // Drive out_ready cycle by cycle until the cycle after DONE (or abort/reset point).
  task automatic drive(input int p, input int abort_idx, input int rst_at);
    int end_t, j;
    end_t = p + 3*AS + 2 + rdy_pat.size();
    while (cyc < end_t) begin
      j = cyc - (p + 3*AS + 1);
      if (j >= 0 && j < rdy_pat.size()) out_ready = rdy_pat[j];
      else out_ready = 1'($urandom_range(1));
      if (abort_idx >= 0 && out_valid && matrix_index == 6'(abort_idx)) begin
        do_abort();
        return;
      end
      if (rst_at >= 0 && cyc == rst_at) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    chk("left_ren", ren_q.size(), 32'd0);
    chk("left_alu", alu_q.size(), 32'd0);
    chk("left_idx", idx_q.size(), 32'd0);
    chk("left_done", done_q.size(), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_cycle_num", 32'(cycle_num), 32'd0);
    chk("after_matrix_index", 32'(matrix_index), 32'd0);
  endtask

  initial begin
    int p;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero();
    rst = 1'b0;
    @(posedge clk); #1;

    build_pattern(0, 0, 0);
    launch(10'h100, 10'h020, 1'b0, p);
    drive(p, -1, -1);

    build_pattern(7, 5, 0);
    launch(10'($urandom), 10'($urandom), 1'b0, p);
    drive(p, -1, -1);

    build_pattern(0, 0, 0);
    launch(10'h3F8, 10'h3FC, 1'b0, p);
    drive(p, -1, -1);

    repeat (4) begin
      build_pattern(0, 0, 1);
      launch(10'($urandom), 10'($urandom), 1'b0, p);
      drive(p, -1, -1);
    end

    build_pattern(0, 0, 0);
    launch(10'($urandom), 10'($urandom), 1'b0, p);
    drive(p, 12, -1);
    build_pattern(0, 0, 0);
    launch(10'h100, 10'h020, 1'b0, p);
    drive(p, -1, -1);

    build_pattern(0, 0, 1);
    launch(10'($urandom), 10'($urandom), 1'b0, p);
    drive(p, -1, p + 20);
    build_pattern(0, 0, 0);
    launch(10'h055, 10'h2AA, 1'b0, p);
    drive(p, -1, -1);

    build_pattern(0, 0, 0);
    launch(10'h200, 10'h300, 1'b1, p);
    drive(p, -1, -1);
    build_pattern(0, 0, 1);
    launch(10'h1F0, 10'h010, 1'b0, p);
    drive(p, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
